// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder sequencer.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int unsigned cnt_w(int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/fulladder.sv
// Single full-adder cell, reused once per clock by the serial sequencer.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic c_out,
    output logic sum
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: latches operands on start, adds one bit per clock LSB first,
// then presents {cout,sum} with a one-cycle done pulse.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned     CntW    = cnt_w(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             cell_sum, cell_carry;

    fulladder u_cell (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c_in  (carry_q),
        .c_out (cell_carry),
        .sum   (cell_sum)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                // Result fills from the MSB end so bit 0 lands in place after WIDTH shifts.
                res_sh_d = (res_sh_q >> 1) | (WIDTH'(cell_sum) << (WIDTH - 1));
                carry_d  = cell_carry;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == LastBit) begin
                    sum_d   = res_sh_d;
                    cout_d  = cell_carry;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench: three lanes (WIDTH 1, 2, 8) share clock and reset; stimulus
// pushes expected results, a monitor pops and compares on each falling edge.
module tb_serial_adder_ctrl;

    localparam int NL = 3;

    typedef struct {
        logic [16:0] res;
        int          due;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NL-1:0] start;
    logic [NL-1:0] cin;
    logic [NL-1:0] busy;
    logic [NL-1:0] done;
    logic [NL-1:0] cout;
    logic [15:0]   a   [NL];
    logic [15:0]   b   [NL];
    logic [15:0]   sum [NL];

    int          cyc    = 0;
    int          errors = 0;
    int          checks = 0;
    int          last_acc [NL];
    logic [16:0] held     [NL];
    exp_t        exp_q    [NL][$];

    function automatic int lw(int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 8);
    endfunction

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int unsigned W = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
        logic [W-1:0] s;

        serial_adder_ctrl #(.WIDTH(W)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start[g]),
            .a     (a[g][W-1:0]),
            .b     (b[g][W-1:0]),
            .cin   (cin[g]),
            .busy  (busy[g]),
            .done  (done[g]),
            .sum   (s),
            .cout  (cout[g])
        );

        assign sum[g] = 16'(s);
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [16:0] result(int i);
        return 17'(sum[i]) | (17'(cout[i]) << lw(i));
    endfunction

    task automatic chk(string name, int i, logic [16:0] act, logic [16:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s lane%0d (width %0d) cyc %0d: got %0h, expected %0h",
                     name, i, lw(i), cyc, act, req);
        end
    endtask

    // Monitor: runs on every falling clock edge and right after an async reset assertion.
    always begin
        @(negedge clk or negedge rst_n);
        #1;
        for (int i = 0; i < NL; i++) begin
            if (!rst_n) begin
                chk("reset_busy", i, 17'(busy[i]), 17'd0);
                chk("reset_done", i, 17'(done[i]), 17'd0);
                chk("reset_result", i, result(i), 17'd0);
                held[i] = '0;
                exp_q[i].delete();
            end else begin
                logic ed;
                logic eb;
                ed = 1'b0;
                while (exp_q[i].size() > 0 && exp_q[i][0].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_done lane%0d cyc %0d: got no done, expected done at %0d",
                             i, cyc, exp_q[i][0].due);
                    void'(exp_q[i].pop_front());
                end
                if (exp_q[i].size() > 0 && exp_q[i][0].due == cyc) begin
                    ed      = 1'b1;
                    held[i] = exp_q[i][0].res;
                    void'(exp_q[i].pop_front());
                end
                eb = (cyc >= last_acc[i]) && (cyc <= last_acc[i] + lw(i));
                chk("done", i, 17'(done[i]), 17'(ed));
                chk("busy", i, 17'(busy[i]), 17'(eb));
                chk("result", i, result(i), held[i]);
            end
        end
    end

    task automatic issue(int i, logic s, logic [15:0] av, logic [15:0] bv, logic ci);
        logic [15:0] m;
        m        = 16'((17'h1 << lw(i)) - 17'h1);
        start[i] = s;
        a[i]     = av & m;
        b[i]     = bv & m;
        cin[i]   = ci;
    endtask

    // Reference model: an idle adder takes a new request at most once per WIDTH+2 edges,
    // and the answer is plain integer addition, due WIDTH edges after acceptance.
    task automatic step();
        for (int i = 0; i < NL; i++) begin
            if (rst_n && start[i] && (cyc + 1 >= last_acc[i] + lw(i) + 2)) begin
                exp_t e;
                last_acc[i] = cyc + 1;
                e.res = 17'(a[i]) + 17'(b[i]) + 17'(cin[i]);
                e.due = cyc + 1 + lw(i);
                exp_q[i].push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all(int n);
        for (int i = 0; i < NL; i++) issue(i, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (n) step();
    endtask

    initial begin
        for (int i = 0; i < NL; i++) begin
            last_acc[i] = -1000;
            held[i]     = '0;
            issue(i, 1'b0, 16'h0, 16'h0, 1'b0);
        end
        @(posedge clk);
        #1;
        repeat (2) step();
        rst_n = 1'b1;
        idle_all(2);

        // Width 2: 3+3, then 1+2, then 1+2+1.
        issue(1, 1'b1, 16'h3, 16'h3, 1'b0); step();
        idle_all(4);
        issue(1, 1'b1, 16'h1, 16'h2, 1'b0); step();
        idle_all(4);
        issue(1, 1'b1, 16'h1, 16'h2, 1'b1); step();
        idle_all(4);

        // Width 2: re-requests during ADD and DONE are ignored.
        issue(1, 1'b1, 16'h3, 16'h0, 1'b0); step();
        issue(1, 1'b0, 16'h0, 16'h0, 1'b0); step();
        issue(1, 1'b1, 16'h0, 16'h0, 1'b0); step(); step();
        issue(1, 1'b0, 16'h0, 16'h0, 1'b0); step(); step();
        issue(1, 1'b1, 16'h2, 16'h1, 1'b1); step();
        idle_all(4);

        // Width 8: start held high across two back-to-back additions.
        issue(2, 1'b1, 16'hFF, 16'h01, 1'b1); step();
        issue(2, 1'b1, 16'h80, 16'h80, 1'b0);
        repeat (12) step();
        idle_all(12);

        // Width 8: asynchronous reset in the 4th ADD cycle.
        issue(2, 1'b1, 16'h55, 16'h0F, 1'b0); step();
        issue(2, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) step();
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < NL; i++) last_acc[i] = -1000;
        repeat (2) step();
        rst_n = 1'b1;
        idle_all(12);
        issue(2, 1'b1, 16'h12, 16'h34, 1'b0); step();
        idle_all(12);

        // Width 1: every combination of a, b, cin.
        for (int v = 0; v < 8; v++) begin
            issue(0, 1'b1, 16'(v & 1), 16'((v >> 1) & 1), 1'(v >> 2)); step();
            issue(0, 1'b0, 16'h0, 16'h0, 1'b0);
            repeat (3) step();
        end

        // Random traffic on all lanes, including operand changes while busy.
        repeat (400) begin
            for (int i = 0; i < NL; i++)
                issue(i, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                      1'($urandom_range(0, 1)));
            step();
        end
        idle_all(14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
